// File: rtl/dcache_pkg.sv
// Shared geometry constants and miss-FSM state encoding for the data cache.
package dcache_pkg;

    localparam int OFFSET_W = 5;
    localparam int INDEX_W  = 5;
    localparam int TAG_W    = 32 - INDEX_W - OFFSET_W;

    typedef enum logic [2:0] {
        IDLE,
        MISS,
        WRITEBACK,
        READMISS,
        REFILL
    } state_e;

endpackage

// File: rtl/dcache_sram.sv
// Direct-mapped tag/valid/dirty/data store: combinational read, clocked write.
module dcache_sram
    import dcache_pkg::*;
#(
    parameter int LINES      = 1 << INDEX_W,
    parameter int TW         = TAG_W,
    parameter int BLOCK_BITS = 256,
    localparam int IW        = $clog2(LINES)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [IW-1:0]         rd_idx,
    output logic                  rd_valid,
    output logic                  rd_dirty,
    output logic [TW-1:0]         rd_tag,
    output logic [BLOCK_BITS-1:0] rd_line,
    input  logic                  we,
    input  logic [IW-1:0]         wr_idx,
    input  logic [TW-1:0]         wr_tag,
    input  logic                  wr_dirty,
    input  logic [BLOCK_BITS-1:0] wr_line
);

    logic [LINES-1:0]      valid_q;
    logic [LINES-1:0]      dirty_q;
    logic [TW-1:0]         tag_q  [LINES];
    logic [BLOCK_BITS-1:0] data_q [LINES];

    assign rd_valid = valid_q[rd_idx];
    assign rd_dirty = dirty_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_line  = data_q[rd_idx];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (we) begin
            valid_q[wr_idx] <= 1'b1;
            dirty_q[wr_idx] <= wr_dirty;
        end
    end

    // Tag and data arrays keep their contents across reset
    always_ff @(posedge clk_i) begin
        if (we) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= wr_line;
        end
    end

endmodule

// File: rtl/dcache_miss_ctrl.sv
// Write-back, write-allocate direct-mapped dcache with blocking miss FSM.
// Define DCACHE_PERF_CNT_EN to add hit_cnt_o / miss_cnt_o counters.
module dcache_miss_ctrl
    import dcache_pkg::*;
#(
    parameter int LINES      = 1 << INDEX_W,
    parameter int BLOCK_BITS = 256
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  p1_req_i,
    input  logic                  p1_we_i,
    input  logic [31:0]           p1_addr_i,
    input  logic [31:0]           p1_data_i,
    output logic [31:0]           p1_data_o,
    output logic                  p1_stall_o,
    output logic                  mem_enable_o,
    output logic                  mem_write_o,
    output logic [31:0]           mem_addr_o,
    output logic [BLOCK_BITS-1:0] mem_data_o,
    input  logic [BLOCK_BITS-1:0] mem_data_i,
    input  logic                  mem_ack_i
`ifdef DCACHE_PERF_CNT_EN
    ,
    output logic [31:0]           hit_cnt_o,
    output logic [31:0]           miss_cnt_o
`endif
);

    localparam int IW = $clog2(LINES);
    localparam int TW = 32 - OFFSET_W - IW;
    localparam int WW = $clog2(BLOCK_BITS / 32);

    state_e                state_q, state_d;
    logic [IW-1:0]         miss_idx_q;
    logic [TW-1:0]         miss_tag_q;
    logic [IW-1:0]         req_idx, line_idx;
    logic [TW-1:0]         req_tag, line_tag;
    logic [WW-1:0]         word;
    logic                  idle, hit, miss;
    logic                  rd_valid, rd_dirty;
    logic [TW-1:0]         rd_tag;
    logic [BLOCK_BITS-1:0] rd_line, merged, wr_line;
    logic                  we, wr_dirty;
    logic                  unused_addr;

    assign req_idx     = p1_addr_i[OFFSET_W +: IW];
    assign req_tag     = p1_addr_i[31 -: TW];
    assign word        = p1_addr_i[2 +: WW];
    assign unused_addr = ^p1_addr_i[1:0];

    // Outside IDLE the array is steered to the latched miss line
    assign idle     = (state_q == IDLE);
    assign line_idx = idle ? req_idx : miss_idx_q;
    assign line_tag = idle ? req_tag : miss_tag_q;

    assign hit        = idle & p1_req_i & rd_valid & (rd_tag == req_tag);
    assign miss       = idle & p1_req_i & ~hit;
    assign p1_stall_o = p1_req_i & ~hit;
    assign p1_data_o  = hit ? rd_line[{word, 5'b0} +: 32] : '0;

    always_comb begin
        merged = rd_line;
        merged[{word, 5'b0} +: 32] = p1_data_i;
    end

    assign we       = (hit & p1_we_i) | ((state_q == READMISS) & mem_ack_i);
    assign wr_dirty = idle;
    assign wr_line  = idle ? merged : mem_data_i;

    dcache_sram #(
        .LINES      (LINES),
        .TW         (TW),
        .BLOCK_BITS (BLOCK_BITS)
    ) u_sram (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .rd_idx   (line_idx),
        .rd_valid (rd_valid),
        .rd_dirty (rd_dirty),
        .rd_tag   (rd_tag),
        .rd_line  (rd_line),
        .we       (we),
        .wr_idx   (line_idx),
        .wr_tag   (line_tag),
        .wr_dirty (wr_dirty),
        .wr_line  (wr_line)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            miss_idx_q <= '0;
            miss_tag_q <= '0;
        end else begin
            state_q <= state_d;
            if (miss) begin
                miss_idx_q <= req_idx;
                miss_tag_q <= req_tag;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_data_o   = '0;
        unique case (state_q)
            IDLE: begin
                if (miss) state_d = MISS;
            end
            MISS: begin
                state_d = (rd_valid && rd_dirty) ? WRITEBACK : READMISS;
            end
            WRITEBACK: begin
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b1;
                mem_addr_o   = {rd_tag, miss_idx_q, {OFFSET_W{1'b0}}};
                mem_data_o   = rd_line;
                if (mem_ack_i) state_d = READMISS;
            end
            READMISS: begin
                mem_enable_o = 1'b1;
                mem_addr_o   = {miss_tag_q, miss_idx_q, {OFFSET_W{1'b0}}};
                if (mem_ack_i) state_d = REFILL;
            end
            REFILL: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef DCACHE_PERF_CNT_EN
    // The replayed hit that completes a miss is not counted as a hit
    logic replay_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
            replay_q   <= 1'b0;
        end else begin
            if (hit && !replay_q) hit_cnt_o <= hit_cnt_o + 32'd1;
            if (miss) miss_cnt_o <= miss_cnt_o + 32'd1;
            if (miss) replay_q <= 1'b1;
            else if (idle) replay_q <= 1'b0;
        end
    end
`endif

endmodule
